fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that produces the `pcPlus4_IF` / `instr_IF` pair consumed by the IF/ID pipeline register. It owns the program counter and runs a req/ack handshake to instruction memory with variable latency. It honours the same `stall` signal the IF/ID register sees, and applies taken-branch/jump redirects from ID. When no instruction is ready, it presents a NOP bubble, so IF/ID always captures either a valid instruction or a harmless NOP.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_INSTR`, 32'h0000_0000, encoding driven on `instr_IF` during bubbles.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `stall`  in  1  hazard stall; same signal driving IF/ID `stall`.
- `redirect`  in  1  taken branch/jump resolved in ID this cycle.
- `redirect_target`  in  32  new PC; bits [1:0] ignored (forced 00).
- `imem_req`  out  1  fetch request, held until ack.
- `imem_addr`  out  32  word address of request (= PC), stable while `imem_req`.
- `imem_ack`  in  1  response valid this cycle; sampled only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `pcPlus4_IF`  out  32  PC+4 of presented instruction; 0 during bubble.
- `instr_IF`  out  32  presented instruction; `NOP_INSTR` during bubble.
- `fetch_valid`  out  1  1 when `instr_IF` is a real, unsquashed instruction.

## Operation
- States: IDLE, FETCH, READY, DRAIN. 2-bit encoding.
- IDLE: entered on reset; `imem_req`=0. Goes to FETCH next cycle unconditionally.
- FETCH: `imem_req`=1, `imem_addr`=PC.
  - On `imem_ack`: latch `imem_rdata` into instruction buffer, go to READY.
  - On `redirect` without ack: PC <= target, go to DRAIN.
  - On `redirect` with ack: PC <= target, discard data, stay FETCH. `imem_req` drops for zero cycles; the new address appears next cycle.
- READY: `instr_IF`=buffer, `pcPlus4_IF`=PC+4, `fetch_valid`=1, `imem_req`=0.
  - `redirect`=1 (priority over `stall`): outputs forced to bubble combinationally in the same cycle, PC <= target, go to FETCH.
  - else `stall`=0: PC <= PC+4, go to FETCH.
  - else `stall`=1: hold buffer and PC, stay READY.
- DRAIN: `imem_req`=1 with the old, stale address held, so the in-flight response still completes. On ack, drop the data and go to FETCH with the redirected PC. A further `redirect` in DRAIN only updates PC.
- Bubble outputs (IDLE/FETCH/DRAIN, or READY with `redirect`): `instr_IF`=`NOP_INSTR`, `pcPlus4_IF`=0, `fetch_valid`=0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- `stall` in FETCH/DRAIN has no effect on the handshake.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, buffer=`NOP_INSTR`, `imem_req`=0, `instr_IF`=`NOP_INSTR`, `pcPlus4_IF`=0, `fetch_valid`=0.
- First `imem_req` is asserted in the first cycle after `rst` deasserts plus one (IDLE→FETCH).
- Memory latency: ack may arrive the same cycle as req (zero-wait). The instruction then appears on `instr_IF` the next cycle.
- Throughput with zero-wait memory and no stalls: one instruction per 2 cycles (FETCH, READY alternate).
- `rst` mid-handshake: immediate return to IDLE. A late `imem_ack` arriving while not requesting is ignored.
- Outputs are registered-state derived, except for the `redirect` squash term (combinational from `redirect`).

## Configuration
- `FETCH_BUBBLE_CNT_EN`: when defined, adds output `bubble_count` (32 bits, reset 0). It increments, wrapping, on every cycle where `fetch_valid`=0 and `stall`=0, i.e. each NOP actually captured by IF/ID.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000, zero-wait memory returning addr-tagged words -> `imem_addr` sequence 0x400000, 0x400004, ...; `pcPlus4_IF`=0x400004 with `instr_IF`=word(0x400000).
- Ack delayed 3 cycles -> `imem_req`/`imem_addr` held stable 4 cycles; bubbles (`instr_IF`=0, `fetch_valid`=0) until the cycle after ack.
- `stall`=1 for 5 cycles in READY -> `instr_IF`/`pcPlus4_IF` unchanged, no new `imem_req`. PC advances by 4 only after `stall` drops.
- `redirect`=1, target 0x0000_1003, in READY -> same-cycle `instr_IF`=NOP; next request at 0x0000_1000.
- `redirect` during FETCH with ack 2 cycles later -> stale data never presented (`fetch_valid`=0); next request at the target.
- PC 32'hFFFF_FFFC fetched, `stall`=0 -> `pcPlus4_IF`=0 and next `imem_addr`=0. With `FETCH_BUBBLE_CNT_EN`, `bubble_count` equals the number of unstalled bubble cycles observed.

Source files
------------

// File: rtl/fetch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory req/ack handshake between fetch and imem.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : IF stage: owns the PC, fetches over a variable-latency req/ack
//            port and presents instr/pcPlus4 (or a NOP bubble) to IF/ID.
//            Optional FETCH_BUBBLE_CNT_EN adds a captured-bubble counter.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              stall,
  input  wire              redirect,
  input  wire  [31:0]      redirect_target,
  fetch_unit_if.master     imem,
  output logic [31:0]      pcPlus4_IF,
  output logic [31:0]      instr_IF,
  output logic             fetch_valid
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0]      bubble_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READY = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] buf_q,   buf_d;
  logic        req_q,   req_d;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_present;

  always_comb begin
    w_target   = redirect_target & ~32'h0000_0003;
    w_pc_plus4 = pc_q + 32'd4;
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          pc_d    = w_target;
          // A response arriving with the redirect is simply dropped; otherwise
          // the outstanding request must still be drained.
          state_d = imem.imem_ack ? S_FETCH : S_DRAIN;
        end else if (imem.imem_ack) begin
          buf_d   = imem.imem_rdata;
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (redirect) begin
          pc_d    = w_target;
          state_d = S_FETCH;
        end else if (!stall) begin
          pc_d    = w_pc_plus4;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          pc_d = w_target;
        end
        if (imem.imem_ack) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_d  = (state_d == S_FETCH) || (state_d == S_DRAIN);
    // Address only follows the PC when a fresh fetch starts; DRAIN keeps the
    // stale address so the in-flight response can complete.
    addr_d = (state_d == S_FETCH) ? pc_d : addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      buf_q   <= NOP_INSTR;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      req_q   <= req_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  // Redirect squashes the presented instruction within the same cycle.
  assign w_present   = (state_q == S_READY) && !redirect;
  assign fetch_valid = w_present;
  assign instr_IF    = w_present ? buf_q      : NOP_INSTR;
  assign pcPlus4_IF  = w_present ? w_pc_plus4 : 32'd0;

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (!w_present && !stall) begin
      bubble_count_d = bubble_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count_q <= 32'd0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Randomized scoreboard bench for fetch_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_RST_PC = 32'h0040_0000;
  localparam logic [31:0] C_NOP    = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] pcPlus4_IF;
  logic [31:0] instr_IF;
  logic        fetch_valid;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_count;
`endif

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC  (C_RST_PC),
    .NOP_INSTR (C_NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem            (imem),
    .pcPlus4_IF      (pcPlus4_IF),
    .instr_IF        (instr_IF),
    .fetch_valid     (fetch_valid)
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    .bubble_count    (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Transaction-level reference model state
  exp_t        q[$];
  logic [31:0] next_pc;     // PC of the next instruction IF/ID should capture
  bit          buffered;    // an instruction has been delivered and awaits capture
  bit          stale;       // outstanding request was overtaken by a redirect
  bit          in_txn;
  logic [31:0] txn_addr;
  int          lat, lat_cnt;
  bit          exp_valid;
  int          captures;
  int          bub_model;

  // Knobs
  int          p_redir, p_stall, min_lat, max_lat;
  bit          force_redir;
  logic [31:0] force_tgt;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle();
    logic [31:0] tgt;
    bit          ack, useful;
    @(negedge clk);
    stall    = ($urandom_range(99) < p_stall);
    redirect = 1'b0;
    if (force_redir) begin
      redirect    = 1'b1;
      tgt         = force_tgt;
      force_redir = 1'b0;
    end else begin
      if ($urandom_range(99) < p_redir) redirect = 1'b1;
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(7))) : $urandom;
    end
    redirect_target = tgt;

    ack = 1'b0;
    if (imem.imem_req) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        txn_addr = imem.imem_addr;
        lat      = $urandom_range(max_lat, min_lat);
        lat_cnt  = 0;
        if (!stale) chk("fetch_addr", imem.imem_addr, next_pc);
      end else begin
        chk("addr_stable", imem.imem_addr, txn_addr);
      end
      if (lat_cnt == lat) ack = 1'b1;
      else lat_cnt++;
      imem.imem_rdata = word_of(imem.imem_addr);
    end else begin
      ack             = ($urandom_range(7) == 0);
      imem.imem_rdata = $urandom;
    end
    imem.imem_ack = ack;

    useful    = ack && imem.imem_req && !redirect && !stale;
    exp_valid = buffered && !redirect;
    if (buffered) begin
      if (redirect) begin
        buffered = 1'b0;
      end else if (!stall) begin
        q.push_back('{pc4: next_pc + 32'd4, instr: word_of(next_pc)});
        next_pc  = next_pc + 32'd4;
        buffered = 1'b0;
        captures++;
      end
    end
    if (imem.imem_req && ack) begin
      in_txn = 1'b0;
      stale  = 1'b0;
    end else if (imem.imem_req && redirect) begin
      stale = 1'b1;
    end
    if (redirect) next_pc = tgt & ~32'h3;
    if (useful) buffered = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    redirect      = 1'b0;
    stall         = 1'b0;
    imem.imem_ack = 1'b0;
    q.delete();
    buffered  = 1'b0;
    stale     = 1'b0;
    in_txn    = 1'b0;
    exp_valid = 1'b0;
    next_pc   = C_RST_PC;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_instr", instr_IF, C_NOP);
    chk("rst_pc4", pcPlus4_IF, 32'd0);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("rst_bubble_count", bubble_count, 32'd0);
`endif
    rst = 1'b0;
  endtask

  // Monitor: pops expectations whenever IF/ID captures a valid instruction.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      bub_model = 0;
    end else begin
`ifdef FETCH_BUBBLE_CNT_EN
      chk("bubble_count", bubble_count, 32'(bub_model));
`endif
      if (!exp_valid && !stall) bub_model++;
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, exp_valid});
      if (!fetch_valid) begin
        chk("bubble_instr", instr_IF, C_NOP);
        chk("bubble_pc4", pcPlus4_IF, 32'd0);
      end else if (!stall) begin
        if (q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL capture_unexpected: got pc4=%h instr=%h expected no capture", pcPlus4_IF, instr_IF);
        end else begin
          e = q.pop_front();
          chk("capture_pc4", pcPlus4_IF, e.pc4);
          chk("capture_instr", instr_IF, e.instr);
        end
      end
    end
  end

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'd0;
    captures    = 0;
    bub_model   = 0;
    force_redir = 1'b0;
    force_tgt   = 32'd0;
    p_redir = 0; p_stall = 0; min_lat = 0; max_lat = 0;
    do_reset();

    // Zero-wait sequential fetch from the reset PC
    run(20);
    // Fixed 3-cycle latency
    min_lat = 3; max_lat = 3;
    run(24);
    // Heavy stalling in READY
    min_lat = 0; max_lat = 1; p_stall = 80;
    run(40);
    // Misaligned redirect target
    p_stall = 0; force_redir = 1'b1; force_tgt = 32'h0000_1003;
    run(12);
    // Redirect during a slow fetch: drain the stale response
    min_lat = 2; max_lat = 2;
    run(1);
    force_redir = 1'b1; force_tgt = 32'h0000_2000;
    run(16);
    // PC wrap-around
    min_lat = 0; max_lat = 0; force_redir = 1'b1; force_tgt = 32'hFFFF_FFF8;
    run(12);
    // Fully randomized traffic
    min_lat = 0; max_lat = 4; p_redir = 8; p_stall = 30;
    run(2000);
    // Reset in the middle of a handshake
    min_lat = 3; max_lat = 3; p_redir = 0; p_stall = 0;
    run(3);
    do_reset();
    min_lat = 0; max_lat = 3; p_redir = 5; p_stall = 25;
    run(300);

    p_redir = 0; p_stall = 0;
    run(20);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("enough_captures", {31'd0, (captures >= 100)}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
